// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counter with a borrow chain and an IDLE/RUN/HOLD/DONE control FSM.
// Counts a loaded decimal value down to zero, one step per tick, and pulses done on expiry.
module bcd_down_timer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   out,
    output logic                  brw,
    output logic                  zero,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [W-1:0]   r_out;
    logic [W-1:0]   w_next_out;
    logic [W-1:0]   w_dec_val;
    logic [W-1:0]   w_sat_val;
    logic           r_brw;
    logic           r_busy;
    logic           r_done;
    logic           w_next_done;
    logic           w_borrow;
    logic           w_step;
    logic           w_dec_zero;

    // Ripple borrow from digit 0 upward; a digit at 0 wraps to 9 and keeps borrowing.
    always_comb begin
        w_borrow  = 1'b1;
        w_dec_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_borrow) begin
                if (r_out[4*i +: 4] == 4'd0) begin
                    w_dec_val[4*i +: 4] = 4'd9;
                end else begin
                    w_dec_val[4*i +: 4] = r_out[4*i +: 4] - 4'd1;
                    w_borrow            = 1'b0;
                end
            end else begin
                w_dec_val[4*i +: 4] = r_out[4*i +: 4];
            end
        end
    end

    always_comb begin
        w_sat_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_sat_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    assign w_dec_zero = (w_dec_val == '0);
    // A decrement happens only when nothing of higher priority claims the cycle.
    assign w_step     = (r_state == S_RUN) && tick && !pause && !load;

    always_comb begin
        w_next_state = r_state;
        w_next_out   = r_out;
        w_next_done  = 1'b0;
        if (load) begin
            w_next_out   = w_sat_val;
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (r_out != '0) begin
                            w_next_state = S_RUN;
                        end else begin
                            w_next_state = S_DONE;
                            w_next_done  = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_next_state = S_HOLD;
                    end else if (tick) begin
                        w_next_out = w_dec_val;
                        if (w_dec_zero) begin
                            w_next_state = S_DONE;
                            w_next_done  = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!pause && start) begin
                        w_next_state = S_RUN;
                    end
                end
                default: begin
                    w_next_state = S_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_brw   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_out   <= w_next_out;
            r_brw   <= w_step && (r_out[3:0] == 4'd0);
            r_busy  <= (w_next_state == S_RUN) || (w_next_state == S_HOLD);
            r_done  <= w_next_done;
        end
    end

    assign out       = r_out;
    assign brw       = r_brw;
    assign zero      = (r_out == '0);
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule
